// File: rtl/cc_threshold_comparator.sv
// Multi-channel threshold comparator with hysteresis and persistence filtering.
// Optional macro CC_THRESHOLDCMP_SIGNED_EN selects two's-complement comparisons.
module cc_threshold_comparator #(
  parameter int NUMBER_DATAWIDTH = 8,
  parameter int NUMBER_CHANNELS  = 4,
  parameter int PERSIST_COUNT    = 3
) (
  input  logic                                        CC_THRESHOLDCMP_CLOCK_50,
  input  logic                                        CC_THRESHOLDCMP_RESET_InLow,
  input  logic                                        CC_THRESHOLDCMP_clear_In,
  input  logic                                        CC_THRESHOLDCMP_valid_In,
  input  logic [NUMBER_CHANNELS*NUMBER_DATAWIDTH-1:0] CC_THRESHOLDCMP_data_InBUS,
  input  logic [NUMBER_DATAWIDTH-1:0]                 CC_THRESHOLDCMP_thrHigh_InBUS,
  input  logic [NUMBER_DATAWIDTH-1:0]                 CC_THRESHOLDCMP_thrLow_InBUS,
  output logic [NUMBER_CHANNELS-1:0]                  CC_THRESHOLDCMP_flag_OutBUS,
  output logic [NUMBER_CHANNELS-1:0]                  CC_THRESHOLDCMP_rise_OutBUS,
  output logic [NUMBER_CHANNELS-1:0]                  CC_THRESHOLDCMP_fall_OutBUS,
  output logic                                        CC_THRESHOLDCMP_valid_Out
);

  localparam int W  = NUMBER_DATAWIDTH;
  localparam int CW = $clog2(PERSIST_COUNT + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(PERSIST_COUNT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Strict greater-than in the selected number representation.
  function automatic logic is_above(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef CC_THRESHOLDCMP_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  // Strict less-than in the selected number representation.
  function automatic logic is_below(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef CC_THRESHOLDCMP_SIGNED_EN
    return $signed(a) < $signed(b);
`else
    return a < b;
`endif
  endfunction

  logic [W-1:0]               sample_s [NUMBER_CHANNELS];
  logic [NUMBER_CHANNELS-1:0] qual_s;
  logic [NUMBER_CHANNELS-1:0] state_r;
  logic [NUMBER_CHANNELS-1:0] rise_r;
  logic [NUMBER_CHANNELS-1:0] fall_r;
  logic [CW-1:0]              cnt_r [NUMBER_CHANNELS];
  logic                       valid_r;

  for (genvar g = 0; g < NUMBER_CHANNELS; g++) begin : g_slice
    assign sample_s[g] = CC_THRESHOLDCMP_data_InBUS[g*W +: W];
  end

  // Each state only looks at its own exit condition; equality never qualifies.
  always_comb begin
    qual_s = '0;
    for (int i = 0; i < NUMBER_CHANNELS; i++) begin
      if (state_r[i]) begin
        qual_s[i] = CC_THRESHOLDCMP_valid_In && is_below(sample_s[i], CC_THRESHOLDCMP_thrLow_InBUS);
      end else begin
        qual_s[i] = CC_THRESHOLDCMP_valid_In && is_above(sample_s[i], CC_THRESHOLDCMP_thrHigh_InBUS);
      end
    end
  end

  // Per-channel LOW/HIGH state, persistence counters and edge pulses.
  always_ff @(posedge CC_THRESHOLDCMP_CLOCK_50) begin
    if (!CC_THRESHOLDCMP_RESET_InLow) begin
      state_r <= '0;
      rise_r  <= '0;
      fall_r  <= '0;
      valid_r <= 1'b0;
      for (int i = 0; i < NUMBER_CHANNELS; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      valid_r <= CC_THRESHOLDCMP_valid_In;
      rise_r  <= '0;
      fall_r  <= '0;
      if (CC_THRESHOLDCMP_clear_In) begin
        // Clear drops everything silently, including any coincident sample.
        state_r <= '0;
        for (int i = 0; i < NUMBER_CHANNELS; i++) begin
          cnt_r[i] <= '0;
        end
      end else if (CC_THRESHOLDCMP_valid_In) begin
        for (int i = 0; i < NUMBER_CHANNELS; i++) begin
          if (qual_s[i]) begin
            if (cnt_r[i] == LAST_CNT) begin
              state_r[i] <= ~state_r[i];
              cnt_r[i]   <= '0;
              if (state_r[i]) begin
                fall_r[i] <= 1'b1;
              end else begin
                rise_r[i] <= 1'b1;
              end
            end else begin
              cnt_r[i] <= cnt_r[i] + CNT_ONE;
            end
          end else begin
            cnt_r[i] <= '0;
          end
        end
      end else begin
        // Gaps hold state and counters so a run can span them.
        state_r <= state_r;
      end
    end
  end

  assign CC_THRESHOLDCMP_flag_OutBUS = state_r;
  assign CC_THRESHOLDCMP_rise_OutBUS = rise_r;
  assign CC_THRESHOLDCMP_fall_OutBUS = fall_r;
  assign CC_THRESHOLDCMP_valid_Out   = valid_r;

endmodule

// File: tb/tb_cc_threshold_comparator.sv
// Directed self-checking bench for cc_threshold_comparator (W=8, CH=4, PERSIST=3).
module tb_cc_threshold_comparator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        vin;
  logic [31:0] data;
  logic [7:0]  thr_h;
  logic [7:0]  thr_l;
  logic [3:0]  flag;
  logic [3:0]  rise;
  logic [3:0]  fall;
  logic        vout;

  int checks   = 0;
  int failures = 0;

  cc_threshold_comparator #(
    .NUMBER_DATAWIDTH(8),
    .NUMBER_CHANNELS (4),
    .PERSIST_COUNT   (3)
  ) dut (
    .CC_THRESHOLDCMP_CLOCK_50     (clk),
    .CC_THRESHOLDCMP_RESET_InLow  (rst_n),
    .CC_THRESHOLDCMP_clear_In     (clr),
    .CC_THRESHOLDCMP_valid_In     (vin),
    .CC_THRESHOLDCMP_data_InBUS   (data),
    .CC_THRESHOLDCMP_thrHigh_InBUS(thr_h),
    .CC_THRESHOLDCMP_thrLow_InBUS (thr_l),
    .CC_THRESHOLDCMP_flag_OutBUS  (flag),
    .CC_THRESHOLDCMP_rise_OutBUS  (rise),
    .CC_THRESHOLDCMP_fall_OutBUS  (fall),
    .CC_THRESHOLDCMP_valid_Out    (vout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] f, input logic [3:0] r,
                            input logic [3:0] fl, input logic v);
    check({tag, ".flag"}, {28'd0, flag}, {28'd0, f});
    check({tag, ".rise"}, {28'd0, rise}, {28'd0, r});
    check({tag, ".fall"}, {28'd0, fall}, {28'd0, fl});
    check({tag, ".vout"}, {31'd0, vout}, {31'd0, v});
  endtask

  // Present one cycle of inputs, then sample just after the registering edge.
  task automatic step(input logic r_n, input logic c, input logic v, input logic [31:0] d);
    @(negedge clk);
    rst_n = r_n;
    clr   = c;
    vin   = v;
    data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic v, input logic [31:0] d);
    step(1'b1, 1'b0, v, d);
  endtask

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    vin   = 1'b1;
    data  = 32'hFFFF_FFFF;
    thr_h = 8'd100;
    thr_l = 8'd50;

    // Reset held with qualifying data.
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    expect_out("rst0", 4'h0, 4'h0, 4'h0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    expect_out("rst1", 4'h0, 4'h0, 4'h0, 1'b0);

    // Two qualifying samples after release are not enough; a 0 resets the run.
    sample(1'b1, 32'hFFFF_FFFF);
    expect_out("post_rst0", 4'h0, 4'h0, 4'h0, 1'b1);
    sample(1'b1, 32'hFFFF_FFFF);
    expect_out("post_rst1", 4'h0, 4'h0, 4'h0, 1'b1);
    sample(1'b1, 32'h0000_0000);
    expect_out("post_rst2", 4'h0, 4'h0, 4'h0, 1'b1);

    // Equality with thrHigh never qualifies.
    for (int i = 0; i < 3; i++) sample(1'b1, 32'd100);
    expect_out("eq_high", 4'h0, 4'h0, 4'h0, 1'b1);

    // Set path on ch0.
    sample(1'b1, 32'd101);
    expect_out("set1", 4'h0, 4'h0, 4'h0, 1'b1);
    sample(1'b1, 32'd101);
    expect_out("set2", 4'h0, 4'h0, 4'h0, 1'b1);
    sample(1'b1, 32'd101);
    expect_out("set3", 4'h1, 4'h1, 4'h0, 1'b1);
    sample(1'b0, 32'd0);
    expect_out("set_after", 4'h1, 4'h0, 4'h0, 1'b0);

    // Hysteresis band holds HIGH; 49 x3 releases; 50 x3 does nothing.
    for (int i = 0; i < 10; i++) sample(1'b1, 32'd75);
    expect_out("band", 4'h1, 4'h0, 4'h0, 1'b1);
    sample(1'b1, 32'd49);
    sample(1'b1, 32'd49);
    expect_out("rel2", 4'h1, 4'h0, 4'h0, 1'b1);
    sample(1'b1, 32'd49);
    expect_out("rel3", 4'h0, 4'h0, 4'h1, 1'b1);
    sample(1'b1, 32'd50);
    expect_out("rel_after", 4'h0, 4'h0, 4'h0, 1'b1);
    sample(1'b1, 32'd50);
    sample(1'b1, 32'd50);
    expect_out("eq_low", 4'h0, 4'h0, 4'h0, 1'b1);

    // Run interrupted by a band sample.
    sample(1'b1, 32'd101);
    sample(1'b1, 32'd101);
    sample(1'b1, 32'd80);
    sample(1'b1, 32'd101);
    sample(1'b1, 32'd101);
    expect_out("interrupt", 4'h0, 4'h0, 4'h0, 1'b1);
    sample(1'b1, 32'd80);

    // Gaps do not break a run; ignored data during gaps.
    sample(1'b1, 32'd101);
    for (int i = 0; i < 4; i++) sample(1'b0, 32'd0);
    expect_out("gap", 4'h0, 4'h0, 4'h0, 1'b0);
    sample(1'b1, 32'd101);
    expect_out("gap2", 4'h0, 4'h0, 4'h0, 1'b1);
    sample(1'b1, 32'd101);
    expect_out("gap3", 4'h1, 4'h1, 4'h0, 1'b1);

    // Bring ch1 HIGH while ch0 sits in the band.
    for (int i = 0; i < 3; i++) sample(1'b1, {16'd0, 8'd101, 8'd75});
    expect_out("ch1_set", 4'h3, 4'h2, 4'h0, 1'b1);

    // Clear collides with a qualifying release sample on ch1.
    step(1'b1, 1'b1, 1'b1, {16'd0, 8'd20, 8'd75});
    expect_out("clear", 4'h0, 4'h0, 4'h0, 1'b1);
    for (int i = 0; i < 3; i++) sample(1'b1, {16'd0, 8'd20, 8'd75});
    expect_out("clear_after", 4'h0, 4'h0, 4'h0, 1'b1);

    // Counter cleared by clear: two samples before a clear plus one after do not set.
    sample(1'b1, 32'd101);
    sample(1'b1, 32'd101);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    expect_out("clear_idle", 4'h0, 4'h0, 4'h0, 1'b0);
    sample(1'b1, 32'd101);
    expect_out("clear_cnt", 4'h0, 4'h0, 4'h0, 1'b1);
    sample(1'b1, 32'd0);

    // Coincident rises on ch0 and ch3.
    for (int i = 0; i < 3; i++) sample(1'b1, {8'd200, 16'd0, 8'd255});
    expect_out("multi", 4'h9, 4'h9, 4'h0, 1'b1);
    for (int i = 0; i < 3; i++) sample(1'b1, 32'd0);
    expect_out("multi_fall", 4'h0, 4'h0, 4'h9, 1'b1);

    // 0x80 on ch2 against thrHigh=100, thrLow=0.
    thr_l = 8'd0;
    for (int i = 0; i < 3; i++) sample(1'b1, {8'd0, 8'h80, 16'd0});
`ifdef CC_THRESHOLDCMP_SIGNED_EN
    expect_out("signed", 4'h0, 4'h0, 4'h0, 1'b1);
`else
    expect_out("signed", 4'h4, 4'h4, 4'h0, 1'b1);
`endif

    // Reset mid-run overrides clear and valid.
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
    expect_out("rst_mid", 4'h0, 4'h0, 4'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
